// File: rtl/imem_loader.sv
// Instruction-memory loader: stalls the CPU while a little-endian byte stream
// is packed into words and written to memory, then drains for a few cycles.
module imem_loader #(
    parameter int              N         = 32,
    parameter int              AW        = 7,
    parameter int              FLUSH_CYC = 3,
    parameter logic [N-1:0]    NOP       = 32'h8b1f03ff
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   load_words,
    input  logic          abort,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    input  logic [AW-1:0] cpu_addr,
    output logic [N-1:0]  cpu_q,
    output logic          cpu_hold,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [N-1:0]  mem_wdata,
    input  logic [N-1:0]  mem_q,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    // Handshake: a byte moves on a rising edge where rx_valid and rx_ready
    // are both high; rx_ready depends only on registered state.
    state_t          state_q, state_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [23:0]     asm_q, asm_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [AW:0]     target_q, target_d;
    logic [AW:0]     issued_q, issued_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic            mem_we_q, mem_we_d;
    logic [N-1:0]    mem_wdata_q, mem_wdata_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_RUN;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            waddr_q     <= '0;
            target_q    <= '0;
            issued_q    <= '0;
            flush_cnt_q <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            asm_q       <= asm_d;
            waddr_q     <= waddr_d;
            target_q    <= target_d;
            issued_q    <= issued_d;
            flush_cnt_q <= flush_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Stop accepting bytes once every requested word has been assembled.
    assign rx_ready = (state_q == S_LOAD) && (issued_q != target_q);
    assign accept   = rx_valid && rx_ready;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        waddr_d     = waddr_q;
        target_d    = target_q;
        issued_d    = issued_q;
        flush_cnt_d = flush_cnt_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = err_q;

        if (mem_we_q) begin
            waddr_d = waddr_q + 1'b1;
        end

        case (state_q)
            S_RUN: begin
                if (start) begin
                    state_d    = S_LOAD;
                    target_d   = (load_words == '0) ? {1'b1, {AW{1'b0}}} : load_words;
                    byte_cnt_d = '0;
                    waddr_d    = '0;
                    issued_d   = '0;
                    err_d      = 1'b0;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d     = S_FLUSH;
                    err_d       = 1'b1;
                    byte_cnt_d  = '0;
                    flush_cnt_d = '0;
                end else begin
                    if (accept) begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0:    asm_d[7:0]   = rx_data;
                            2'd1:    asm_d[15:8]  = rx_data;
                            2'd2:    asm_d[23:16] = rx_data;
                            default: begin
                                mem_wdata_d = N'({rx_data, asm_q});
                                mem_we_d    = 1'b1;
                                issued_d    = issued_q + 1'b1;
                            end
                        endcase
                    end
                    if (mem_we_q && (issued_q == target_q)) begin
                        state_d     = S_FLUSH;
                        flush_cnt_d = '0;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == FW'(FLUSH_CYC - 1)) begin
                    state_d = S_RUN;
                    done_d  = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    assign cpu_hold  = (state_q != S_RUN);
    assign busy      = cpu_hold;
    assign cpu_q     = (state_q == S_RUN) ? mem_q : NOP;
    assign mem_addr  = (state_q == S_RUN) ? cpu_addr : waddr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a word-level model of the byte stream
// predicts every memory write; a per-cycle monitor checks outputs against it.
module tb_imem_loader;
    localparam int N = 32;
    localparam int AW = 7;
    localparam logic [N-1:0] NOP = 32'h8b1f03ff;

    logic          clk, reset, start, abort, rx_valid, rx_ready;
    logic [AW:0]   load_words;
    logic [7:0]    rx_data;
    logic [AW-1:0] cpu_addr, mem_addr;
    logic [N-1:0]  cpu_q, mem_wdata, mem_q;
    logic          cpu_hold, mem_we, busy, done, err;
    logic [1:0]    dbg_state;

    logic [N-1:0]    bench_mem [0:127];
    logic [7:0]      tx [0:511];
    logic [AW+N-1:0] exp_q [$];
    int tests_run, tests_failed;
    int hold_cnt, done_cnt, we_cnt;

    imem_loader #(.N(N), .AW(AW), .FLUSH_CYC(3), .NOP(NOP)) dut (
        .clk(clk), .reset(reset), .start(start), .load_words(load_words),
        .abort(abort), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .cpu_addr(cpu_addr), .cpu_q(cpu_q), .cpu_hold(cpu_hold), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_q(mem_q), .busy(busy),
        .done(done), .err(err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: combinational read, synchronous write
    assign mem_q = bench_mem[mem_addr];
    initial begin
        for (int i = 0; i < 128; i++) bench_mem[i] = 32'hc0de0000 + i;
        forever begin
            @(posedge clk);
            if (mem_we) bench_mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // model: complete words among the first 'good' accepted bytes, up to 'words'
    task automatic model_load(input int words, input int good);
        for (int w = 0; w < words; w++) begin
            if (4 * w + 3 < good)
                exp_q.push_back({AW'(w), tx[4*w+3], tx[4*w+2], tx[4*w+1], tx[4*w]});
        end
    endtask

    // per-cycle compare process
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (cpu_hold) begin
                    hold_cnt++;
                    chk("hold_cpu_q", 64'(cpu_q), 64'(NOP));
                    chk("hold_busy", 64'(busy), 64'd1);
                end else begin
                    chk("run_cpu_q", 64'(cpu_q), 64'(bench_mem[cpu_addr]));
                    chk("run_mem_addr", 64'(mem_addr), 64'(cpu_addr));
                    chk("run_rx_ready", 64'(rx_ready), 64'd0);
                    chk("run_busy", 64'(busy), 64'd0);
                end
                if (done) done_cnt++;
                if (mem_we) begin
                    logic [AW+N-1:0] e;
                    we_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 64'({mem_addr, mem_wdata}), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write", 64'({mem_addr, mem_wdata}), 64'(e));
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic clear_counts();
        hold_cnt = 0; done_cnt = 0; we_cnt = 0;
    endtask

    task automatic do_start(input logic [AW:0] lw);
        start = 1'b1; load_words = lw;
        @(posedge clk); #1;
        start = 1'b0; load_words = 8'd3;
    endtask

    task automatic send_bytes(input int n, input int abort_idx, input int start_idx);
        int i, guard;
        logic acc;
        i = 0; guard = 0;
        while (i < n && guard < 2000) begin
            rx_valid = 1'b1; rx_data = tx[i];
            abort = (i == abort_idx);
            start = (i == start_idx);
            acc = rx_ready;
            @(posedge clk); #1;
            rx_valid = 1'b0; abort = 1'b0; start = 1'b0;
            if (acc) i = (i == abort_idx) ? n : i + 1;
            guard++;
        end
        if (guard >= 2000) chk("send_timeout", 64'd1, 64'd0);
        if (abort_idx == n) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 2000; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        if (i >= 2000) chk("idle_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        clear_counts();
        reset = 1'b1; start = 1'b0; abort = 1'b0; rx_valid = 1'b0; rx_data = '0;
        load_words = '0; cpu_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold", 64'(cpu_hold), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // two-word load at full byte rate
        tx[0] = 8'hff; tx[1] = 8'h03; tx[2] = 8'h1f; tx[3] = 8'h8b;
        tx[4] = 8'h01; tx[5] = 8'h00; tx[6] = 8'h00; tx[7] = 8'hf8;
        model_load(2, 8);
        chk("model_w0", 64'(exp_q[0]), 64'({7'd0, 32'h8b1f03ff}));
        chk("model_w1", 64'(exp_q[1]), 64'({7'd1, 32'hf8000001}));
        clear_counts();
        do_start(9'd2);
        chk("t1_state_load", 64'(dbg_state), 64'd1);
        chk("t1_rx_ready", 64'(rx_ready), 64'd1);
        send_bytes(8, -1, -1);
        wait_idle();
        chk("t1_mem0", 64'(bench_mem[0]), 64'h8b1f03ff);
        chk("t1_mem1", 64'(bench_mem[1]), 64'hf8000001);
        chk("t1_hold_cycles", 64'(hold_cnt), 64'd12);
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);
        chk("t1_we_cnt", 64'(we_cnt), 64'd2);
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_drained", 64'(exp_q.size()), 64'd0);

        // RUN: CPU reads through, rx traffic ignored
        cpu_addr = 7'd5;
        #1;
        chk("run_read5", 64'(cpu_q), 64'hc0de0005);
        clear_counts();
        for (int k = 0; k < 4; k++) begin
            rx_valid = k[0]; rx_data = 8'(k + 8'h40);
            @(posedge clk); #1;
            chk("run_rx_ready_low", 64'(rx_ready), 64'd0);
        end
        rx_valid = 1'b0;
        chk("run_no_we", 64'(we_cnt), 64'd0);
        chk("run_no_hold", 64'(hold_cnt), 64'd0);
        cpu_addr = 7'd0;

        // abort after five bytes
        for (int k = 0; k < 16; k++) tx[k] = 8'(8'h10 + k);
        model_load(4, 5);
        clear_counts();
        do_start(9'd4);
        send_bytes(5, 5, -1);
        wait_idle();
        chk("ab5_mem0", 64'(bench_mem[0]), 64'h13121110);
        chk("ab5_mem1", 64'(bench_mem[1]), 64'hf8000001);
        chk("ab5_we_cnt", 64'(we_cnt), 64'd1);
        chk("ab5_hold_cycles", 64'(hold_cnt), 64'd9);
        chk("ab5_done_cnt", 64'(done_cnt), 64'd1);
        chk("ab5_err", 64'(err), 64'd1);
        chk("ab5_drained", 64'(exp_q.size()), 64'd0);

        // abort coinciding with the 4th byte
        for (int k = 0; k < 4; k++) tx[k] = 8'(8'he0 + k);
        model_load(1, 3);
        clear_counts();
        do_start(9'd1);
        send_bytes(4, 3, -1);
        wait_idle();
        chk("ab4_we_cnt", 64'(we_cnt), 64'd0);
        chk("ab4_mem0", 64'(bench_mem[0]), 64'h13121110);
        chk("ab4_hold_cycles", 64'(hold_cnt), 64'd7);
        chk("ab4_done_cnt", 64'(done_cnt), 64'd1);
        chk("ab4_err", 64'(err), 64'd1);

        // start while busy (LOAD and FLUSH) is ignored
        for (int k = 0; k < 4; k++) tx[k] = 8'(8'h20 + k);
        model_load(1, 4);
        clear_counts();
        do_start(9'd1);
        chk("sb_err_cleared", 64'(err), 64'd0);
        send_bytes(4, -1, 1);
        @(posedge clk); #1;
        chk("sb_state_flush", 64'(dbg_state), 64'd2);
        start = 1'b1; load_words = 9'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        chk("sb_we_cnt", 64'(we_cnt), 64'd1);
        chk("sb_mem0", 64'(bench_mem[0]), 64'h23222120);
        chk("sb_hold_cycles", 64'(hold_cnt), 64'd8);
        chk("sb_done_cnt", 64'(done_cnt), 64'd1);
        chk("sb_err", 64'(err), 64'd0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        // reset during the 3rd byte of word 1
        for (int k = 0; k < 8; k++) tx[k] = 8'(8'h30 + k);
        model_load(2, 4);
        clear_counts();
        do_start(9'd2);
        send_bytes(6, -1, -1);
        rx_valid = 1'b1; rx_data = tx[6];
        #2 reset = 1'b1;
        #1;
        chk("mr_hold", 64'(cpu_hold), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_we", 64'(mem_we), 64'd0);
        chk("mr_wdata", 64'(mem_wdata), 64'd0);
        chk("mr_rx_ready", 64'(rx_ready), 64'd0);
        chk("mr_state", 64'(dbg_state), 64'd0);
        @(posedge clk); #3;
        reset = 1'b0; rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mr_we_cnt", 64'(we_cnt), 64'd1);
        chk("mr_mem0", 64'(bench_mem[0]), 64'h33323130);
        chk("mr_mem1", 64'(bench_mem[1]), 64'hf8000001);
        chk("mr_done_cnt", 64'(done_cnt), 64'd0);
        chk("mr_drained", 64'(exp_q.size()), 64'd0);

        // full memory load with load_words = 0
        for (int k = 0; k < 512; k++) tx[k] = 8'(k * 7 + 1);
        model_load(128, 512);
        chk("model_w127", 64'(exp_q[127]), 64'({7'd127, 32'hfaf3ece5}));
        clear_counts();
        do_start(9'd0);
        send_bytes(512, -1, -1);
        wait_idle();
        chk("full_we_cnt", 64'(we_cnt), 64'd128);
        chk("full_hold_cycles", 64'(hold_cnt), 64'd516);
        chk("full_done_cnt", 64'(done_cnt), 64'd1);
        chk("full_drained", 64'(exp_q.size()), 64'd0);
        cpu_addr = 7'd127;
        #1;
        chk("full_read127", 64'(cpu_q), 64'hfaf3ece5);
        cpu_addr = 7'd0;
        #1;
        chk("full_read0", 64'(cpu_q), 64'h160f0801);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter N, default 32: instruction word width.
REQ-002 Parameter AW, default 7: address width; memory holds 2**AW = 128 words.
REQ-003 Parameter FLUSH_CYC, default 3: number of drain cycles after a load.
REQ-004 Parameter NOP, default 32'h8b1f03ff: word fed to the CPU while it is held.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request to begin a program load.
REQ-008 load_words  input  AW+1  word count, sampled on an accepted start; 0 is treated as 2**AW.
REQ-009 abort  input  1  cancels an active load.
REQ-010 rx_valid  input  1  byte-stream valid.
REQ-011 rx_data  input  8  byte-stream data.
REQ-012 rx_ready  output  1  byte accepted when rx_valid and rx_ready are both high.
REQ-013 cpu_addr  input  AW  CPU fetch address.
REQ-014 cpu_q  output  N  instruction returned to the CPU (combinational).
REQ-015 cpu_hold  output  1  stall/hold request to the processor.
REQ-016 mem_addr  output  AW  memory address (combinational mux).
REQ-017 mem_we  output  1  memory write enable (registered).
REQ-018 mem_wdata  output  N  memory write data (registered).
REQ-019 mem_q  input  N  memory read data, combinational on mem_addr.
REQ-020 busy  output  1  high in LOAD or FLUSH.
REQ-021 done  output  1  one-cycle pulse on completion.
REQ-022 err  output  1  sticky abort flag.

Function
REQ-023 FSM states: RUN, LOAD, FLUSH.
REQ-024 RUN: mem_addr=cpu_addr; cpu_q=mem_q; cpu_hold=0; rx_ready=0; rx bytes ignored.
REQ-025 RUN with start=1: go to LOAD; latch load_words; clear byte counter, write address and err.
REQ-026 LOAD: rx_ready=1; cpu_hold=1; cpu_q=NOP; mem_addr=write address.
REQ-027 Word assembly is little-endian: the 1st accepted byte goes to bits [7:0] and the 4th to bits [31:24].
REQ-028 Byte counter is 2 bits and wraps from 3 to 0.
REQ-029 On the edge accepting the 4th byte, mem_wdata is loaded with the assembled word and mem_we is set; mem_we is high for exactly the following cycle.
REQ-030 Write address increments on the edge ending each mem_we cycle.
REQ-031 A new byte accepted during a mem_we cycle is assembled normally; no bytes are lost at the full rate of 1 byte/cycle.
REQ-032 After the write of word number load_words completes, go to FLUSH; no write occurs past that count, so no address wrap.
REQ-033 start while busy is ignored.
REQ-034 abort in LOAD: go to FLUSH; set err; discard any partial word.
REQ-035 abort coinciding with a 4th byte: abort wins; no write occurs.
REQ-036 FLUSH: cpu_hold=1; cpu_q=NOP; rx_ready=0; hold for FLUSH_CYC cycles, then return to RUN.
REQ-037 done pulses in the first RUN cycle after FLUSH, whether the load completed or was aborted.
REQ-038 err is held until the next accepted start or reset.

Reset
REQ-039 Reset forces state RUN; clears mem_we, done, err, counters, mem_wdata and the latched count.
REQ-040 Reset mid-load aborts the load without a write; already-written words remain in memory.
REQ-041 Reset takes priority over start and abort in the same cycle.

Verification
REQ-042 start, load_words=2, bytes ff 03 1f 8b 01 00 00 f8 at 1 byte/cycle -> writes addr0=8b1f03ff, addr1=f8000001; cpu_hold high until FLUSH ends; done=1 once; err=0.
REQ-043 load_words=0, 512 bytes -> 128 writes at addresses 0..127; mem_we never high after address 127.
REQ-044 Abort after 5 bytes -> exactly one write at addr0; err=1; FLUSH lasts 3 cycles; done pulses once.
REQ-045 In RUN, cpu_addr=5 -> cpu_q=mem_q(5); mem_we=0; rx_valid toggling has no effect.
REQ-046 Assert reset during the 3rd byte of word 1 -> outputs return to reset values asynchronously; state is RUN; no write occurs.
REQ-047 Assert start in LOAD and in FLUSH -> load_words is not re-latched; sequence unchanged.
